// File: rtl/mc_sequencer_if.sv
// Shared memory-port handshake between the multi-cycle sequencer and the memory.
interface mc_sequencer_if;
    logic mem_req;
    logic mem_we;
    logic mem_instr;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_instr,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_instr,
        output mem_ready
    );
endinterface

// File: rtl/mc_sequencer.sv
// Multi-cycle RV32I control sequencer: steps FETCH/DECODE/EXEC/MEM/WB over one
// memory port, counts retired instructions and traps on illegal opcodes or timeouts.
module mc_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [6:0]        op_i,
    input  logic              zero_i,
    mc_sequencer_if.master    mem,
    output logic              ir_write_o,
    output logic              alu_out_write_o,
    output logic              mdr_write_o,
    output logic              reg_write_en_o,
    output logic              pc_write_o,
    output logic [2:0]        state_o,
    output logic              trap_o,
    output logic [1:0]        trap_cause_o,
    output logic [CNT_W-1:0]  instret_o
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd7
    } state_e;

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    localparam logic [7:0] WaitLimit = 8'(MEM_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [1:0]       cause_q, cause_d;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] instret_q;

    logic op_legal, is_load, is_store, is_branch, timeout;
    logic req, we, instr, ir_wr, alu_wr, mdr_wr, rf_wr, pc_wr;

    // Zero only steers NPC selection inside the decoder; PCWrite fires either way.
    logic unused_zero;
    assign unused_zero = zero_i;

    assign is_load   = (op_i == OpLoad);
    assign is_store  = (op_i == OpStore);
    assign is_branch = (op_i == OpBranch);
    assign timeout   = !mem.mem_ready && (wait_q == WaitLimit);

    always_comb begin
        op_legal = 1'b0;
        case (op_i)
            OpLui, OpAuipc, OpReg, OpLoad, OpImm,
            OpJalr, OpStore, OpBranch, OpJal: op_legal = 1'b1;
            default: op_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        wait_d  = wait_q;
        req     = 1'b0;
        we      = 1'b0;
        instr   = 1'b0;
        ir_wr   = 1'b0;
        alu_wr  = 1'b0;
        mdr_wr  = 1'b0;
        rf_wr   = 1'b0;
        pc_wr   = 1'b0;

        case (state_q)
            StFetch: begin
                req   = 1'b1;
                instr = 1'b1;
                if (mem.mem_ready) begin
                    ir_wr   = 1'b1;
                    state_d = StDecode;
                end else if (timeout) begin
                    state_d = StTrap;
                    cause_d = 2'b10;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            StDecode: begin
                if (op_legal) begin
                    state_d = StExec;
                end else begin
                    state_d = StTrap;
                    cause_d = 2'b01;
                end
            end
            StExec: begin
                alu_wr = 1'b1;
                if (is_load || is_store) begin
                    state_d = StMem;
                end else if (is_branch) begin
                    pc_wr   = 1'b1;
                    state_d = StFetch;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                req = 1'b1;
                we  = is_store;
                if (mem.mem_ready) begin
                    if (is_store) begin
                        pc_wr   = 1'b1;
                        state_d = StFetch;
                    end else begin
                        mdr_wr  = 1'b1;
                        state_d = StWb;
                    end
                end else if (timeout) begin
                    state_d = StTrap;
                    cause_d = 2'b10;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            StWb: begin
                rf_wr   = 1'b1;
                pc_wr   = 1'b1;
                state_d = StFetch;
            end
            StTrap: ;
            default: begin
                state_d = StTrap;
                cause_d = 2'b01;
            end
        endcase

        if (state_d != state_q) begin
            wait_d = '0;
        end

        // Withdraw any pending access and suppress strobes during reset.
        if (rst_i) begin
            req    = 1'b0;
            we     = 1'b0;
            instr  = 1'b0;
            ir_wr  = 1'b0;
            alu_wr = 1'b0;
            mdr_wr = 1'b0;
            rf_wr  = 1'b0;
            pc_wr  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StFetch;
            cause_q   <= 2'b00;
            wait_q    <= '0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            wait_q  <= wait_d;
            if (pc_wr) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    assign mem.mem_req     = req;
    assign mem.mem_we      = we;
    assign mem.mem_instr   = instr;
    assign ir_write_o      = ir_wr;
    assign alu_out_write_o = alu_wr;
    assign mdr_write_o     = mdr_wr;
    assign reg_write_en_o  = rf_wr;
    assign pc_write_o      = pc_wr;
    assign state_o         = state_q;
    assign trap_o          = (state_q == StTrap);
    assign trap_cause_o    = cause_q;
    assign instret_o       = instret_q;

endmodule

// File: doc/mc_sequencer.md
Name: mc_sequencer

Overview:
Multi-cycle control sequencer for the RV32I core. The combinational decoder resolves per-instruction controls (ALUOp, EXTOp, WDSel, NPCOp); this block decides *when* each architectural register updates. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB over one shared memory port with a ready handshake. It also counts retired instructions and traps on illegal opcodes or memory timeouts.

Parameters:
MEM_TIMEOUT, 16, max consecutive wait cycles with mem_req=1 and mem_ready=0 before trap (legal range 1..255)
CNT_W, 32, width of instret counter

Ports:
clk  in  1  core clock, rising edge
rst  in  1  synchronous active-high reset
Op  in  7  opcode from instruction register; valid from DECODE onward
Zero  in  1  ALU branch-condition flag; sampled in EXEC only
mem_ready  in  1  memory completes current access this cycle
mem_req  out  1  memory access request
mem_we  out  1  write enable; valid with mem_req
mem_instr  out  1  1 = instruction fetch, 0 = data access
IRWrite  out  1  load instruction register
ALUOutWrite  out  1  latch ALU result register
MDRWrite  out  1  latch memory data register
RegWriteEn  out  1  register-file write strobe
PCWrite  out  1  load PC from NPC (target or PC+4 per decoder NPCOp)
state  out  3  current state, for debug
trap  out  1  sticky trap flag
trap_cause  out  2  01 illegal opcode, 10 memory timeout, 00 none
instret  out  CNT_W  retired-instruction count

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7. Codes 5 and 6 are unreachable and go to TRAP with cause 01.
- Outputs are Moore-decoded from the state register, except strobes qualified by mem_ready or Zero (noted below).
- All strobes and mem_req are forced 0 while rst=1.
- Reset, at the clock edge with rst=1: state=FETCH, trap=0, trap_cause=00, instret=0, wait counter=0.
- FETCH:
  - mem_req=1, mem_instr=1, mem_we=0.
  - On mem_ready: IRWrite=1 in the same cycle; next state DECODE.
- DECODE:
  - Exactly one cycle, no strobes.
  - Legal opcodes: 0110111, 0010111, 0110011, 0000011, 0010011, 1100111, 0100011, 1100011, 1101111.
  - Legal opcode -> EXEC; any other -> TRAP, cause 01.
- EXEC:
  - Exactly one cycle, ALUOutWrite=1.
  - Load (0000011) or store (0100011) -> MEM.
  - Branch (1100011): PCWrite=1 in this cycle. NPC already selects target when Zero=1, else PC+4. Increment instret; next state FETCH.
  - All other legal opcodes -> WB.
- MEM:
  - mem_req=1, mem_instr=0, mem_we=1 only for store.
  - On mem_ready, load: MDRWrite=1; next state WB.
  - On mem_ready, store: PCWrite=1 and instret++; next state FETCH.
- WB:
  - One cycle: RegWriteEn=1, PCWrite=1, instret++; next state FETCH.
- TRAP:
  - All strobes and mem_req held 0, trap=1, trap_cause held.
  - Leaves only via rst.
- Invariant: PCWrite asserts exactly once per instruction, in its final cycle, coincident with the instret increment.
- Wait counter:
  - Cleared on every state change.
  - Increments each FETCH/MEM cycle with mem_ready=0.
  - When the counter reaches MEM_TIMEOUT while mem_ready=0: next state TRAP, cause 10.
  - mem_ready on the same cycle as the limit wins; the access completes normally.
- instret wraps modulo 2^CNT_W with no flag.
- Reset mid-access: mem_req drops in the reset cycle. The pending access is abandoned; memory must tolerate request withdrawal.
- Zero-wait cycle counts: R/I-ALU/LUI/AUIPC/JAL/JALR 4, load 5, store 4, branch 3.

Test Plan:
- addi fetched with mem_ready always 1 -> states 0,1,2,4,0. IRWrite in cycle 0, ALUOutWrite in cycle 2, RegWriteEn+PCWrite in cycle 3; instret 0->1.
- lw with 2 fetch wait cycles and 3 data wait cycles -> 10 cycles total. MDRWrite only in the MEM cycle with mem_ready=1, then WB. mem_instr=0 and mem_we=0 throughout MEM.
- sw then beq, first with Zero=1, then Zero=0 -> sw: mem_we=1 in MEM, PCWrite on mem_ready, no RegWriteEn. beq: PCWrite in EXEC in both cases, 3 cycles; instret +3 over the sequence.
- Fetch with mem_ready held 0, MEM_TIMEOUT=16 -> after 16 wait cycles trap=1, cause=10, state=7, mem_req=0. Repeat with mem_ready rising on the 16th wait cycle -> no trap, DECODE next.
- Op=0001111 (fence, unsupported) -> TRAP from DECODE, cause=01, no PCWrite, instret unchanged. Then rst=1 for one cycle -> state=0, trap=0, instret=0.
- rst asserted during a MEM wait of sw -> mem_req=0 and mem_we=0 in the reset cycle, state=FETCH after the edge, no RegWriteEn/PCWrite pulse emitted.
